// File: rtl/branch_resolve_cycle.sv
// Execute-stage branch/jump resolution: registers the D instruction into E,
// resolves the branch condition or jump, and issues a one-cycle fetch redirect
// that also squashes the wrong-path instruction in D.
module branch_resolve_cycle #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ValidD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic [XLEN-1:0]   ImmExtD,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic              BranchD,
    input  logic              JumpD,
    input  logic              JalrD,
    input  logic [2:0]        Funct3D,
    input  logic              StallE,
    output logic              PCSrcE,
    output logic [XLEN-1:0]   PCTargetE,
    output logic              FlushD,
    output logic [XLEN-1:0]   LinkE,
    output logic              LinkValidE,
    output logic [CNT_W-1:0]  RedirectCount
);

    logic             ValidE;
    logic [XLEN-1:0]  PCE;
    logic [XLEN-1:0]  PCPlus4E;
    logic [XLEN-1:0]  ImmExtE;
    logic [XLEN-1:0]  RD1E;
    logic [XLEN-1:0]  RD2E;
    logic             BranchE;
    logic             JumpE;
    logic             JalrE;
    logic [2:0]       Funct3E;
    // Redirect for the current E instruction has already been issued.
    logic             IssuedE;

    logic             cond;
    logic             taken;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  jalr_sum;

    // E pipeline register: hold on stall, bubble after a redirect, else load D.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ValidE   <= 1'b0;
            PCE      <= '0;
            PCPlus4E <= '0;
            ImmExtE  <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            BranchE  <= 1'b0;
            JumpE    <= 1'b0;
            JalrE    <= 1'b0;
            Funct3E  <= 3'b000;
            IssuedE  <= 1'b0;
        end else if (StallE) begin
            // Remember the redirect so a held instruction cannot fire twice.
            if (PCSrcE) begin
                IssuedE <= 1'b1;
            end
        end else if (PCSrcE) begin
            ValidE   <= 1'b0;
            PCE      <= '0;
            PCPlus4E <= '0;
            ImmExtE  <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            BranchE  <= 1'b0;
            JumpE    <= 1'b0;
            JalrE    <= 1'b0;
            Funct3E  <= 3'b000;
            IssuedE  <= 1'b0;
        end else begin
            ValidE   <= ValidD;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            ImmExtE  <= ImmExtD;
            RD1E     <= RD1D;
            RD2E     <= RD2D;
            BranchE  <= BranchD;
            JumpE    <= JumpD;
            JalrE    <= JalrD;
            Funct3E  <= Funct3D;
            IssuedE  <= 1'b0;
        end
    end

    // Branch condition from funct3; 010/011 never taken.
    always_comb begin
        cond = 1'b0;
        unique case (Funct3E)
            3'b000:  cond = (RD1E == RD2E);
            3'b001:  cond = (RD1E != RD2E);
            3'b100:  cond = ($signed(RD1E) < $signed(RD2E));
            3'b101:  cond = ($signed(RD1E) >= $signed(RD2E));
            3'b110:  cond = (RD1E < RD2E);
            3'b111:  cond = (RD1E >= RD2E);
            default: cond = 1'b0;
        endcase
    end

    // Target select (JALR wins over JAL/branch) and redirect outputs.
    always_comb begin
        jalr_sum = RD1E + ImmExtE;
        target   = PCE + ImmExtE;
        if (JalrE) begin
            target = {jalr_sum[XLEN-1:1], 1'b0};
        end
        taken      = ValidE & (JalrE | JumpE | (BranchE & cond));
        PCSrcE     = taken & ~IssuedE;
        FlushD     = PCSrcE;
        PCTargetE  = ValidE ? target : '0;
        LinkE      = PCPlus4E;
        LinkValidE = ValidE & (JumpE | JalrE);
    end

    // Saturating redirect counter for performance debug.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RedirectCount <= '0;
        end else if (PCSrcE && (RedirectCount != {CNT_W{1'b1}})) begin
            RedirectCount <= RedirectCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_cycle.sv
// Directed self-checking bench for branch_resolve_cycle. A second, narrow-counter
// instance shares the stimulus so counter saturation is reachable in few cycles.
module tb_branch_resolve_cycle;

    logic        clk;
    logic        rst;
    logic        ValidD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic [31:0] ImmExtD;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic        BranchD;
    logic        JumpD;
    logic        JalrD;
    logic [2:0]  Funct3D;
    logic        StallE;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        FlushD;
    logic [31:0] LinkE;
    logic        LinkValidE;
    logic [15:0] RedirectCount;

    logic        s_PCSrcE;
    logic [31:0] s_PCTargetE;
    logic        s_FlushD;
    logic [31:0] s_LinkE;
    logic        s_LinkValidE;
    logic [3:0]  s_RedirectCount;

    int checks;
    int failures;

    branch_resolve_cycle #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ValidD(ValidD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ImmExtD(ImmExtD), .RD1D(RD1D), .RD2D(RD2D), .BranchD(BranchD), .JumpD(JumpD),
        .JalrD(JalrD), .Funct3D(Funct3D), .StallE(StallE), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .FlushD(FlushD), .LinkE(LinkE), .LinkValidE(LinkValidE),
        .RedirectCount(RedirectCount)
    );

    branch_resolve_cycle #(.XLEN(32), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .ValidD(ValidD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ImmExtD(ImmExtD), .RD1D(RD1D), .RD2D(RD2D), .BranchD(BranchD), .JumpD(JumpD),
        .JalrD(JalrD), .Funct3D(Funct3D), .StallE(StallE), .PCSrcE(s_PCSrcE),
        .PCTargetE(s_PCTargetE), .FlushD(s_FlushD), .LinkE(s_LinkE),
        .LinkValidE(s_LinkValidE), .RedirectCount(s_RedirectCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] r1, input logic [31:0] r2, input logic br,
                         input logic j, input logic jr, input logic [2:0] f3);
        ValidD   = v;
        PCD      = pc;
        PCPlus4D = pc + 32'd4;
        ImmExtD  = imm;
        RD1D     = r1;
        RD2D     = r2;
        BranchD  = br;
        JumpD    = j;
        JalrD    = jr;
        Funct3D  = f3;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        StallE   = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        #2;
        check("rst_pcsrc", {31'b0, PCSrcE}, 32'h0);
        check("rst_target", PCTargetE, 32'h0);
        check("rst_flush", {31'b0, FlushD}, 32'h0);
        check("rst_linkvalid", {31'b0, LinkValidE}, 32'h0);
        check("rst_count", {16'b0, RedirectCount}, 32'h0);
        step();
        rst = 1'b0;

        // BEQ taken, with a wrong-path JAL sitting in D during the redirect.
        drive(1'b1, 32'h40, 32'h20, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        check("beq_pcsrc", {31'b0, PCSrcE}, 32'h1);
        check("beq_target", PCTargetE, 32'h60);
        check("beq_flush", {31'b0, FlushD}, 32'h1);
        check("beq_linkvalid", {31'b0, LinkValidE}, 32'h0);
        drive(1'b1, 32'h44, 32'h100, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 3'b000);
        step();
        check("beq_bubble_pcsrc", {31'b0, PCSrcE}, 32'h0);
        check("beq_bubble_target", PCTargetE, 32'h0);
        check("beq_bubble_link", {31'b0, LinkValidE}, 32'h0);
        check("beq_count", {16'b0, RedirectCount}, 32'd1);

        // BLT signed: -1 < 1 is taken.
        drive(1'b1, 32'h100, 32'h8, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0, 3'b100);
        step();
        check("blt_pcsrc", {31'b0, PCSrcE}, 32'h1);
        check("blt_target", PCTargetE, 32'h108);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        check("blt_count", {16'b0, RedirectCount}, 32'd2);

        // BLTU: 0xFFFFFFFF < 1 unsigned is not taken; next JAL enters normally.
        drive(1'b1, 32'h100, 32'h8, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0, 3'b110);
        step();
        check("bltu_pcsrc", {31'b0, PCSrcE}, 32'h0);
        check("bltu_flush", {31'b0, FlushD}, 32'h0);
        check("bltu_target", PCTargetE, 32'h108);
        drive(1'b1, 32'h200, 32'h4, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 3'b000);
        step();
        check("jal_pcsrc", {31'b0, PCSrcE}, 32'h1);
        check("jal_target", PCTargetE, 32'h204);
        check("jal_link", LinkE, 32'h204);
        check("jal_linkvalid", {31'b0, LinkValidE}, 32'h1);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        check("jal_count", {16'b0, RedirectCount}, 32'd3);

        // JALR with JAL and branch also set: JALR target wins, bit0 cleared.
        drive(1'b1, 32'h20, 32'h10, 32'h101, 32'h0, 1'b1, 1'b1, 1'b1, 3'b000);
        step();
        check("jalr_pcsrc", {31'b0, PCSrcE}, 32'h1);
        check("jalr_target", PCTargetE, 32'h110);
        check("jalr_link", LinkE, 32'h24);
        check("jalr_linkvalid", {31'b0, LinkValidE}, 32'h1);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        check("jalr_single_pulse", {31'b0, PCSrcE}, 32'h0);
        check("jalr_count", {16'b0, RedirectCount}, 32'd4);

        // Stall: JAL held for three stalled edges redirects only once.
        drive(1'b1, 32'h300, 32'h40, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 3'b000);
        step();
        check("stall_pcsrc_first", {31'b0, PCSrcE}, 32'h1);
        check("stall_target_first", PCTargetE, 32'h340);
        StallE = 1'b1;
        drive(1'b1, 32'h500, 32'h4, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'b010);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pcsrc_held", {31'b0, PCSrcE}, 32'h0);
            check("stall_flush_held", {31'b0, FlushD}, 32'h0);
            check("stall_target_held", PCTargetE, 32'h340);
            check("stall_link_held", LinkE, 32'h304);
            check("stall_count", {16'b0, RedirectCount}, 32'd5);
        end
        StallE = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        check("stall_release_bubble_target", PCTargetE, 32'h0);
        check("stall_release_bubble_link", {31'b0, LinkValidE}, 32'h0);
        check("stall_release_count", {16'b0, RedirectCount}, 32'd5);

        // Target wraps modulo 2^32.
        drive(1'b1, 32'hFFFF_FFF8, 32'h10, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 3'b000);
        step();
        check("wrap_target", PCTargetE, 32'h8);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        check("wrap_count", {16'b0, RedirectCount}, 32'd6);
        check("small_count", {28'b0, s_RedirectCount}, 32'd6);

        // Asynchronous reset mid-cycle with a taken branch in E.
        drive(1'b1, 32'h40, 32'h20, 32'd7, 32'd7, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        check("prereset_pcsrc", {31'b0, PCSrcE}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pcsrc", {31'b0, PCSrcE}, 32'h0);
        check("async_rst_target", PCTargetE, 32'h0);
        check("async_rst_flush", {31'b0, FlushD}, 32'h0);
        check("async_rst_count", {16'b0, RedirectCount}, 32'h0);
        rst = 1'b0;
        drive(1'b1, 32'h80, 32'h8, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 3'b000);
        #1;
        check("post_rst_before_edge", PCTargetE, 32'h0);
        step();
        check("post_rst_pcsrc", {31'b0, PCSrcE}, 32'h1);
        check("post_rst_target", PCTargetE, 32'h88);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        check("post_rst_count", {16'b0, RedirectCount}, 32'd1);

        // Back-to-back JALs: one redirect every two cycles, 20 in total.
        drive(1'b1, 32'h1000, 32'h40, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 40; i++) begin
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        check("burst_count", {16'b0, RedirectCount}, 32'd21);
        check("small_saturate", {28'b0, s_RedirectCount}, 32'hF);
        step();
        check("small_saturate_hold", {28'b0, s_RedirectCount}, 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
